reg_file_param: RTL

REG_FILE_PARAM -- requirements
Module: reg_file_param

---
 rtl/reg_file_param.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/reg_file_param.sv
// Purpose : parameterised register file with one write port, two combinational
//           read ports, optional write-to-read bypass, optional hardwired zero
//           register and a sequential clear engine (one register per cycle).
// Latency : reads are combinational (0 cycles); writes land at the next rising
//           edge; a clear takes DEPTH cycles after CLEAR is sampled.
// Backpressure: BUSY is high during a clear; writes offered while BUSY are
//           dropped and flagged by a one-cycle WRITE_ERR pulse.
//
// Ports
//   CLK          clock, all state changes on the rising edge
//   RESET        synchronous, active-high reset (overrides WRITE and CLEAR)
//   IN           write data
//   INADDRESS    write address
//   WRITE        write enable
//   OUT1ADDRESS  read address, port 1
//   OUT2ADDRESS  read address, port 2
//   OUT1, OUT2   read data, ports 1 and 2 (combinational)
//   CLEAR        request a sequential clear of every register
//   BUSY         registered, high while the clear sequence runs
//   WRITE_ERR    registered, one-cycle pulse per dropped write
module reg_file_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int ZERO_REG   = 0,
    parameter int BYPASS     = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] IN,
    input  logic [ADDR_WIDTH-1:0] INADDRESS,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
    input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
    output logic [DATA_WIDTH-1:0] OUT1,
    output logic [DATA_WIDTH-1:0] OUT2,
    input  logic                  CLEAR,
    output logic                  BUSY,
    output logic                  WRITE_ERR
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_CLEARING = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   ptr_q;
    logic                    busy_q;
    logic                    write_err_q;
    logic [DATA_WIDTH-1:0]   regs_q [DEPTH];

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    // wr_accept_d: the write is taken at the coming edge (not in reset, not
    // blocked by a running clear). wr_store_d additionally drops writes to the
    // hardwired zero register; such writes are accepted silently, so they do
    // not raise WRITE_ERR.
    logic wr_accept_d;
    logic wr_store_d;
    logic zero_addr_wr;

    always_comb begin
        zero_addr_wr = (ZERO_REG != 0) && (INADDRESS == '0);
        wr_accept_d  = !RESET && WRITE && !busy_q;
        wr_store_d   = wr_accept_d && !zero_addr_wr;
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    // Priority: hardwired zero, then same-cycle forwarding of the accepted
    // write, then the stored contents. Forwarding keys off wr_store_d, so it
    // is automatically off while a clear runs (busy_q blocks the write).
    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic [ADDR_WIDTH-1:0] rd_addr,
        input logic [DATA_WIDTH-1:0] stored,
        input logic                  fwd_vld,
        input logic [ADDR_WIDTH-1:0] fwd_addr,
        input logic [DATA_WIDTH-1:0] fwd_dat
    );
        logic [DATA_WIDTH-1:0] rd_dat;
        rd_dat = stored;
        if ((ZERO_REG != 0) && (rd_addr == '0)) begin
            rd_dat = '0;
        end else if ((BYPASS != 0) && fwd_vld && (rd_addr == fwd_addr)) begin
            rd_dat = fwd_dat;
        end
        return rd_dat;
    endfunction

    always_comb begin
        OUT1 = read_port(OUT1ADDRESS, regs_q[OUT1ADDRESS], wr_store_d, INADDRESS, IN);
        OUT2 = read_port(OUT2ADDRESS, regs_q[OUT2ADDRESS], wr_store_d, INADDRESS, IN);
    end

    // ------------------------------------------------------------------
    // Storage and clear sequencer
    // ------------------------------------------------------------------
    // BUSY mirrors the CLEARING state but is kept as its own flop so the
    // output comes straight from a register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            busy_q      <= 1'b0;
            write_err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            // Any write offered while busy is lost; flag it for one cycle.
            write_err_q <= WRITE && busy_q;

            // A write in the same edge that CLEAR is accepted still lands;
            // the sweep wipes it later.
            if (wr_store_d) begin
                regs_q[INADDRESS] <= IN;
            end

            case (state_q)
                ST_IDLE: begin
                    if (CLEAR) begin
                        state_q <= ST_CLEARING;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CLEARING: begin
                    // CLEAR is ignored here: a request mid-sweep never
                    // restarts the pointer.
                    regs_q[ptr_q] <= '0;
                    ptr_q         <= ptr_q + ADDR_WIDTH'(1);
                    if (ptr_q == LAST_PTR) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY      = busy_q;
    assign WRITE_ERR = write_err_q;

endmodule
